// File: rtl/vrased_pkg.sv
// ---------------------------------------------------------------------------
// vrased_pkg : state encodings, violation indices and counter sizing helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package vrased_pkg;

  localparam int NUM_VIOL = 6;

  localparam int V_XSTACK    = 0;
  localparam int V_AC        = 1;
  localparam int V_ATOMIC    = 2;
  localparam int V_DMAAC     = 3;
  localparam int V_DMADETECT = 4;
  localparam int V_DMAXSTACK = 5;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ASSERT  = 2'd1;
  localparam logic [1:0] ST_WAIT_PC = 2'd2;

  // Bits needed to hold max_val; never below one so a counter always exists.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hwmod_down_counter.sv
// ---------------------------------------------------------------------------
// hwmod_down_counter : loadable down counter that stops at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hwmod_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/vrased_reset_seq.sv
// ---------------------------------------------------------------------------
// vrased_reset_seq : violation-driven core reset sequencer with cause capture
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vrased_reset_seq
  import vrased_pkg::*;
#(
  parameter logic [15:0] RESET_HANDLER = 16'h0000,
  parameter int          RST_CYCLES    = 4,
  parameter int          PC_TIMEOUT    = 255,
  parameter int          CNT_W         = 8
) (
  input  logic                mclk,
  input  logic                reset_n,
  input  logic [NUM_VIOL-1:0] viol,
  input  logic [15:0]         pc,
  input  logic                cause_clr,
  output logic                sys_rst,
  output logic [NUM_VIOL-1:0] cause,
  output logic [CNT_W-1:0]    viol_cnt,
  output logic                seq_busy
);

  localparam int PULSE_W = cnt_width(RST_CYCLES - 1);
  localparam int TMO_W   = cnt_width(PC_TIMEOUT);
  localparam logic [PULSE_W-1:0] C_PULSE_LOAD = PULSE_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   C_TMO_LOAD   = TMO_W'(PC_TIMEOUT);

  logic [1:0]          r_state;
  logic [1:0]          w_next;
  logic [NUM_VIOL-1:0] r_cause;
  logic [CNT_W-1:0]    r_cnt;
  logic w_any, w_event;
  logic w_p_load, w_p_dec, w_p_zero;
  logic w_t_load, w_t_dec, w_t_zero;
  logic w_clr_ok;

  assign w_any = |viol;

  always_comb begin
    w_next   = r_state;
    w_p_load = 1'b0;
    w_p_dec  = 1'b0;
    w_t_load = 1'b0;
    w_t_dec  = 1'b0;
    w_event  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next   = ST_ASSERT;
          w_p_load = 1'b1;
          w_event  = 1'b1;
        end
      end
      ST_ASSERT: begin
        // Mid-pulse violations only accumulate cause; the pulse is never stretched.
        if (!w_p_zero) begin
          w_p_dec = 1'b1;
        end else if (w_any) begin
          w_p_load = 1'b1;
          w_event  = 1'b1;
        end else begin
          w_next   = ST_WAIT_PC;
          w_t_load = 1'b1;
        end
      end
      ST_WAIT_PC: begin
        if (w_any) begin
          w_next   = ST_ASSERT;
          w_p_load = 1'b1;
          w_event  = 1'b1;
        end else if (pc == RESET_HANDLER) begin
          w_next = ST_IDLE;
        end else if (w_t_zero) begin
          w_next   = ST_ASSERT;
          w_p_load = 1'b1;
        end else begin
          w_t_dec = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_clr_ok = cause_clr && (r_state == ST_IDLE) && !w_any;

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cause <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_clr_ok ? '0 : (r_cause | viol);
      if (w_event && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  hwmod_down_counter #(.WIDTH(PULSE_W)) u_pulse_cnt (
    .clk      (mclk),
    .reset_n  (reset_n),
    .load     (w_p_load),
    .load_val (C_PULSE_LOAD),
    .dec      (w_p_dec),
    .zero     (w_p_zero)
  );

  hwmod_down_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
    .clk      (mclk),
    .reset_n  (reset_n),
    .load     (w_t_load),
    .load_val (C_TMO_LOAD),
    .dec      (w_t_dec),
    .zero     (w_t_zero)
  );

  // Combinational so a violation reaches the core in the same cycle.
  assign sys_rst  = (r_state == ST_ASSERT) | w_any;
  assign cause    = r_cause;
  assign viol_cnt = r_cnt;
  assign seq_busy = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_vrased_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_vrased_reset_seq : scoreboard bench for the reset sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vrased_reset_seq;

  localparam int RST_CYCLES = 4;
  localparam int PC_TIMEOUT = 255;

  logic        mclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [5:0]  viol = '0;
  logic [15:0] pc = 16'hFFFF;
  logic        cause_clr = 1'b0;
  logic        sys_rst;
  logic [5:0]  cause;
  logic [7:0]  viol_cnt;
  logic        seq_busy;

  vrased_reset_seq #(
    .RESET_HANDLER (16'h0000),
    .RST_CYCLES    (RST_CYCLES),
    .PC_TIMEOUT    (PC_TIMEOUT),
    .CNT_W         (8)
  ) dut (
    .mclk      (mclk),
    .reset_n   (reset_n),
    .viol      (viol),
    .pc        (pc),
    .cause_clr (cause_clr),
    .sys_rst   (sys_rst),
    .cause     (cause),
    .viol_cnt  (viol_cnt),
    .seq_busy  (seq_busy)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic       rst;
    logic [5:0] cause;
    logic [7:0] cnt;
    logic       busy;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: 0=idle 1=assert 2=wait_pc
  int         m_state = 0;
  int         m_p = 0;
  int         m_t = 0;
  logic [5:0] m_cause = '0;
  int         m_cnt = 0;

  logic       last_rst, last_busy;
  logic [5:0] last_cause;
  logic [7:0] last_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clock(input logic [5:0] v, input logic [15:0] p, input logic clr,
                             input logic rn);
    bit any;
    bit ev;
    any = |v;
    ev  = 0;
    if (!rn) begin
      m_state = 0; m_p = 0; m_t = 0; m_cause = '0; m_cnt = 0;
    end else begin
      if (clr && m_state == 0 && !any) m_cause = '0;
      else m_cause = m_cause | v;
      if (m_state == 0) begin
        if (any) begin m_state = 1; m_p = RST_CYCLES - 1; ev = 1; end
      end else if (m_state == 1) begin
        if (m_p > 0) m_p--;
        else if (any) begin m_p = RST_CYCLES - 1; ev = 1; end
        else begin m_state = 2; m_t = PC_TIMEOUT; end
      end else begin
        if (any) begin m_state = 1; m_p = RST_CYCLES - 1; ev = 1; end
        else if (p == 16'h0000) m_state = 0;
        else if (m_t == 0) begin m_state = 1; m_p = RST_CYCLES - 1; end
        else m_t--;
      end
      if (ev && m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic step(input logic [5:0] v, input logic [15:0] p, input logic clr,
                      input logic rn);
    exp_t e;
    @(negedge mclk);
    viol = v; pc = p; cause_clr = clr; reset_n = rn;
    e.rst   = (m_state == 1) || (|v);
    e.cause = m_cause;
    e.cnt   = 8'(m_cnt);
    e.busy  = (m_state != 0);
    sb.push_back(e);
    #1;
    last_rst = sys_rst; last_cause = cause; last_cnt = viol_cnt; last_busy = seq_busy;
    e = sb.pop_front();
    check_val("sys_rst", {31'd0, last_rst}, {31'd0, e.rst});
    check_val("cause", {26'd0, last_cause}, {26'd0, e.cause});
    check_val("viol_cnt", {24'd0, last_cnt}, {24'd0, e.cnt});
    check_val("seq_busy", {31'd0, last_busy}, {31'd0, e.busy});
    @(posedge mclk);
    model_clock(v, p, clr, rn);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    int n;
    repeat (2) @(posedge mclk);

    // Reset state
    step(6'h00, 16'hFFFF, 1'b0, 1'b0);
    check_val("reset_rst", {31'd0, last_rst}, 32'd0);
    check_val("reset_busy", {31'd0, last_busy}, 32'd0);
    check_val("reset_cnt", {24'd0, last_cnt}, 32'd0);

    // 1: single AC violation from idle
    step(6'h02, 16'hFFFF, 1'b0, 1'b1);
    check_val("t1_rst_same_cycle", {31'd0, last_rst}, 32'd1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t1_cause", {26'd0, last_cause}, 32'h02);
    check_val("t1_cnt", {24'd0, last_cnt}, 32'd1);
    hi = int'(last_rst);
    for (int i = 0; i < 3; i++) begin
      step(6'h00, 16'hFFFF, 1'b0, 1'b1);
      hi += int'(last_rst);
    end
    check_val("t1_assert_cycles", hi, RST_CYCLES);

    // 2: pc reaches handler on third wait cycle, then clear cause
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t2_rst_low", {31'd0, last_rst}, 32'd0);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'h0000, 1'b0, 1'b1);
    step(6'h00, 16'hFFFF, 1'b1, 1'b1);
    check_val("t2_idle", {31'd0, last_busy}, 32'd0);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t2_cause_clr", {26'd0, last_cause}, 32'd0);

    // 3: pc never returns -> timeout re-assert
    step(6'h01, 16'hFFFF, 1'b0, 1'b1);
    repeat (RST_CYCLES) step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    n = 0;
    while (n < 400) begin
      step(6'h00, 16'hFFFF, 1'b0, 1'b1);
      if (last_rst) break;
      n++;
    end
    check_val("t3_wait_cycles", n, PC_TIMEOUT + 1);
    check_val("t3_cnt", {24'd0, last_cnt}, 32'd2);
    repeat (RST_CYCLES - 1) step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'h0000, 1'b0, 1'b1);

    // 4: violation inside the pulse does not extend it
    step(6'h02, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h20, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t4_not_extended", {31'd0, last_rst}, 32'd0);
    check_val("t4_cause5", {31'd0, last_cause[5]}, 32'd1);
    check_val("t4_cnt", {24'd0, last_cnt}, 32'd3);
    step(6'h00, 16'h0000, 1'b0, 1'b1);

    // 5: violation and handler pc together -> assert wins
    step(6'h02, 16'hFFFF, 1'b0, 1'b1);
    repeat (RST_CYCLES) step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h01, 16'h0000, 1'b0, 1'b1);
    check_val("t5_rst", {31'd0, last_rst}, 32'd1);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t5_busy", {31'd0, last_busy}, 32'd1);
    check_val("t5_assert", {31'd0, last_rst}, 32'd1);
    check_val("t5_cnt", {24'd0, last_cnt}, 32'd5);
    repeat (RST_CYCLES - 1) step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    step(6'h00, 16'h0000, 1'b0, 1'b1);

    // 6: continuous violation saturates the counter, then reset mid-sequence
    repeat (1100) step(6'h01, 16'hFFFF, 1'b0, 1'b1);
    check_val("t6_sat", {24'd0, last_cnt}, 32'hFF);
    step(6'h00, 16'hFFFF, 1'b0, 1'b0);
    step(6'h00, 16'hFFFF, 1'b0, 1'b1);
    check_val("t6_rst", {31'd0, last_rst}, 32'd0);
    check_val("t6_cause", {26'd0, last_cause}, 32'd0);
    check_val("t6_cnt", {24'd0, last_cnt}, 32'd0);
    check_val("t6_busy", {31'd0, last_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
